// File: rtl/vending_machine_multi_pkg.sv
// Shared types and coin constants for the multi-product vending controller.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NICKLE  = 2'b00,
    COIN_DIME    = 2'b01,
    COIN_QUARTER = 2'b10
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_VEND    = 2'b10,
    ST_CHANGE  = 2'b11
  } state_e;

  localparam int unsigned NICKLE_VAL  = 5;
  localparam int unsigned DIME_VAL    = 10;
  localparam int unsigned QUARTER_VAL = 25;

endpackage

// File: rtl/vending_machine_multi_change_gen.sv
// Greedy change selection: largest coin not exceeding the remaining credit.
module vm_change_gen
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output coin_e               o_coin_type,
  output logic [CREDIT_W-1:0] o_coin_value
);

  // Pick the coin type and its value from the credit
  always_comb begin
    if (i_credit >= CREDIT_W'(QUARTER_VAL)) begin
      o_coin_type  = COIN_QUARTER;
      o_coin_value = CREDIT_W'(QUARTER_VAL);
    end else if (i_credit >= CREDIT_W'(DIME_VAL)) begin
      o_coin_type  = COIN_DIME;
      o_coin_value = CREDIT_W'(DIME_VAL);
    end else begin
      o_coin_type  = COIN_NICKLE;
      o_coin_value = CREDIT_W'(NICKLE_VAL);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit accumulation, priced vend handshake,
// cancel/refund and one-coin-per-handshake change return.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int N_PROD   = 4,
  parameter int SEL_W    = ($clog2(N_PROD) > 1) ? $clog2(N_PROD) : 1,
  parameter int CREDIT_W = 8,
  parameter int MAX_CRED = 100,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10}
) (
  input  logic                i_clk,
  input  logic                ni_rst,
  input  logic                i_nickle,
  input  logic                i_dime,
  input  logic                i_quarter,
  input  logic                i_sel_valid,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_cancel,
  output logic                o_vend_valid,
  output logic [SEL_W-1:0]    o_vend_id,
  input  logic                i_vend_ready,
  output logic                o_coin_valid,
  output logic [1:0]          o_coin_type,
  input  logic                i_coin_ready,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_coin_reject,
  output logic                o_sel_denied,
  output logic                o_busy
);

  localparam logic [CREDIT_W:0] MAX_L    = (CREDIT_W+1)'(MAX_CRED);
  localparam logic [SEL_W:0]    N_PROD_L = (SEL_W+1)'(N_PROD);

  if ((MAX_CRED % 5 != 0) || (MAX_CRED >= (2 ** CREDIT_W))) begin : g_bad_max
    $error("MAX_CRED must be a multiple of 5 and below 2**CREDIT_W");
  end

  logic [CREDIT_W-1:0] price_tbl_s [N_PROD];
  for (genvar g = 0; g < N_PROD; g++) begin : g_price
    localparam logic [CREDIT_W-1:0] PRICE_G = PRICES[g*CREDIT_W +: CREDIT_W];
    assign price_tbl_s[g] = PRICE_G;
    if ((int'(PRICE_G) == 0) || (int'(PRICE_G) % 5 != 0) || (int'(PRICE_G) > MAX_CRED)) begin : g_bad
      $error("price must be a nonzero multiple of 5 not above MAX_CRED");
    end
  end

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_valid_q, vend_valid_d;
  logic [SEL_W-1:0]    vend_id_q, vend_id_d;
  logic                coin_valid_q, coin_valid_d;
  coin_e               coin_type_q, coin_type_d;
  logic [CREDIT_W-1:0] coin_value_q, coin_value_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_denied_q, sel_denied_d;
  logic                busy_q, busy_d;

  logic [2:0]          coin_vec_s;
  logic                coin_any_s;
  logic                coin_one_s;
  logic [CREDIT_W-1:0] coin_in_val_s;
  logic [CREDIT_W:0]   sum_s;
  logic                sel_ok_s;
  logic [CREDIT_W-1:0] sel_price_s;
  coin_e               gen_type_s;
  logic [CREDIT_W-1:0] gen_value_s;

  assign coin_vec_s  = {i_quarter, i_dime, i_nickle};
  assign coin_any_s  = |coin_vec_s;
  assign coin_one_s  = $onehot(coin_vec_s);
  assign sum_s       = {1'b0, credit_q} + {1'b0, coin_in_val_s};
  assign sel_ok_s    = ({1'b0, i_sel} < N_PROD_L);
  assign sel_price_s = sel_ok_s ? price_tbl_s[i_sel] : '0;

  // Value of the single inserted coin
  always_comb begin
    case (coin_vec_s)
      3'b001:  coin_in_val_s = CREDIT_W'(NICKLE_VAL);
      3'b010:  coin_in_val_s = CREDIT_W'(DIME_VAL);
      3'b100:  coin_in_val_s = CREDIT_W'(QUARTER_VAL);
      default: coin_in_val_s = '0;
    endcase
  end

  // The next change coin is derived from next-cycle credit, so it is registered
  // alongside the credit and stays consistent during a stalled handshake.
  vm_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
    .i_credit     (credit_d),
    .o_coin_type  (gen_type_s),
    .o_coin_value (gen_value_s)
  );

  // Next-state, credit and output decisions
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_valid_d  = vend_valid_q;
    vend_id_d     = vend_id_q;
    coin_valid_d  = coin_valid_q;
    coin_reject_d = 1'b0;
    sel_denied_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (i_cancel && (state_q == ST_COLLECT)) begin
          state_d       = ST_CHANGE;
          coin_valid_d  = 1'b1;
          coin_reject_d = coin_any_s;
        end else if (i_sel_valid) begin
          coin_reject_d = coin_any_s;
          if (sel_ok_s && (credit_q >= sel_price_s)) begin
            credit_d     = credit_q - sel_price_s;
            vend_id_d    = i_sel;
            vend_valid_d = 1'b1;
            state_d      = ST_VEND;
          end else begin
            sel_denied_d = 1'b1;
          end
        end else if (coin_one_s && (sum_s <= MAX_L)) begin
          credit_d = sum_s[CREDIT_W-1:0];
          state_d  = ST_COLLECT;
        end else begin
          coin_reject_d = coin_any_s;
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_any_s;
        if (i_vend_ready) begin
          vend_valid_d = 1'b0;
          if (credit_q != '0) begin
            state_d      = ST_CHANGE;
            coin_valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_VEND;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_any_s;
        if (i_coin_ready) begin
          credit_d = credit_q - coin_value_q;
          if (credit_q == coin_value_q) begin
            state_d      = ST_IDLE;
            coin_valid_d = 1'b0;
          end else begin
            state_d = ST_CHANGE;
          end
        end else begin
          state_d = ST_CHANGE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        credit_d     = '0;
        vend_valid_d = 1'b0;
        coin_valid_d = 1'b0;
      end
    endcase
    coin_type_d  = coin_valid_d ? gen_type_s : COIN_NICKLE;
    coin_value_d = gen_value_s;
    busy_d       = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // State, credit and registered outputs
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      vend_valid_q  <= 1'b0;
      vend_id_q     <= '0;
      coin_valid_q  <= 1'b0;
      coin_type_q   <= COIN_NICKLE;
      coin_value_q  <= '0;
      coin_reject_q <= 1'b0;
      sel_denied_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_valid_q  <= vend_valid_d;
      vend_id_q     <= vend_id_d;
      coin_valid_q  <= coin_valid_d;
      coin_type_q   <= coin_type_d;
      coin_value_q  <= coin_value_d;
      coin_reject_q <= coin_reject_d;
      sel_denied_q  <= sel_denied_d;
      busy_q        <= busy_d;
    end
  end

  assign o_vend_valid  = vend_valid_q;
  assign o_vend_id     = vend_id_q;
  assign o_coin_valid  = coin_valid_q;
  assign o_coin_type   = coin_type_q;
  assign o_credit      = credit_q;
  assign o_coin_reject = coin_reject_q;
  assign o_sel_denied  = sel_denied_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Randomized and directed bench for vending_machine_multi against a transaction-level model.
module tb_vending_machine_multi;

  localparam int N_PROD   = 4;
  localparam int SEL_W    = 2;
  localparam int CREDIT_W = 8;
  localparam int MAX_CRED = 100;
  // Product 0 costs 25c, 1 costs 20c, 2 costs 15c, 3 costs 10c.
  localparam logic [N_PROD*CREDIT_W-1:0] TB_PRICES = {8'd10, 8'd15, 8'd20, 8'd25};

  logic                i_clk = 1'b0;
  logic                ni_rst = 1'b0;
  logic                i_nickle = 1'b0, i_dime = 1'b0, i_quarter = 1'b0;
  logic                i_sel_valid = 1'b0;
  logic [SEL_W-1:0]    i_sel = '0;
  logic                i_cancel = 1'b0;
  logic                i_vend_ready = 1'b0;
  logic                i_coin_ready = 1'b0;
  logic                o_vend_valid, o_coin_valid, o_coin_reject, o_sel_denied, o_busy;
  logic [SEL_W-1:0]    o_vend_id;
  logic [1:0]          o_coin_type;
  logic [CREDIT_W-1:0] o_credit;

  vending_machine_multi #(
    .N_PROD(N_PROD), .SEL_W(SEL_W), .CREDIT_W(CREDIT_W),
    .MAX_CRED(MAX_CRED), .PRICES(TB_PRICES)
  ) dut (
    .i_clk(i_clk), .ni_rst(ni_rst),
    .i_nickle(i_nickle), .i_dime(i_dime), .i_quarter(i_quarter),
    .i_sel_valid(i_sel_valid), .i_sel(i_sel), .i_cancel(i_cancel),
    .o_vend_valid(o_vend_valid), .o_vend_id(o_vend_id), .i_vend_ready(i_vend_ready),
    .o_coin_valid(o_coin_valid), .o_coin_type(o_coin_type), .i_coin_ready(i_coin_ready),
    .o_credit(o_credit), .o_coin_reject(o_coin_reject), .o_sel_denied(o_sel_denied),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Transaction-level model: what the machine is doing, not how it encodes it.
  int  price_tbl [N_PROD] = '{25, 20, 15, 10};
  int  m_credit = 0;
  bit  m_vending = 1'b0;
  bit  m_paying = 1'b0;
  int  m_vid = 0;
  bit  m_rej = 1'b0;
  bit  m_den = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int greedy_type(input int c);
    return (c >= 25) ? 2 : ((c >= 10) ? 1 : 0);
  endfunction

  function automatic int coin_cents(input int t);
    return (t == 2) ? 25 : ((t == 1) ? 10 : 5);
  endfunction

  task automatic model_reset();
    m_credit = 0; m_vending = 0; m_paying = 0; m_vid = 0; m_rej = 0; m_den = 0;
  endtask

  task automatic model_step();
    int n_coins = int'(i_nickle) + int'(i_dime) + int'(i_quarter);
    int cents   = 5 * int'(i_nickle) + 10 * int'(i_dime) + 25 * int'(i_quarter);
    m_rej = 0; m_den = 0;
    if (m_vending) begin
      m_rej = (n_coins > 0);
      if (i_vend_ready) begin
        m_vending = 0;
        m_paying  = (m_credit > 0);
      end
    end else if (m_paying) begin
      m_rej = (n_coins > 0);
      if (i_coin_ready) begin
        m_credit -= coin_cents(greedy_type(m_credit));
        m_paying  = (m_credit > 0);
      end
    end else if (i_cancel && m_credit > 0) begin
      m_paying = 1;
      m_rej    = (n_coins > 0);
    end else if (i_sel_valid) begin
      m_rej = (n_coins > 0);
      if (int'(i_sel) < N_PROD && m_credit >= price_tbl[i_sel]) begin
        m_credit -= price_tbl[i_sel];
        m_vid     = int'(i_sel);
        m_vending = 1;
      end else begin
        m_den = 1;
      end
    end else if (n_coins == 1 && m_credit + cents <= MAX_CRED) begin
      m_credit += cents;
    end else begin
      m_rej = (n_coins > 0);
    end
  endtask

  task automatic check_outputs();
    check_eq("credit", 32'(o_credit), 32'(m_credit));
    check_eq("vend_valid", 32'(o_vend_valid), 32'(m_vending));
    if (m_vending) check_eq("vend_id", 32'(o_vend_id), 32'(m_vid));
    check_eq("coin_valid", 32'(o_coin_valid), 32'(m_paying));
    if (m_paying) check_eq("coin_type", 32'(o_coin_type), 32'(greedy_type(m_credit)));
    check_eq("coin_reject", 32'(o_coin_reject), 32'(m_rej));
    check_eq("sel_denied", 32'(o_sel_denied), 32'(m_den));
    check_eq("busy", 32'(o_busy), 32'(m_vending || m_paying));
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then check after the next.
  task automatic step(input bit n, input bit d, input bit q, input bit sv,
                      input logic [SEL_W-1:0] s, input bit c, input bit vr, input bit cr);
    i_nickle = n; i_dime = d; i_quarter = q;
    i_sel_valid = sv; i_sel = s; i_cancel = c;
    i_vend_ready = vr; i_coin_ready = cr;
    model_step();
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic coin_in(input bit n, input bit d, input bit q);
    step(n, d, q, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic select(input logic [SEL_W-1:0] s);
    step(1'b0, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cyc(input bit vr, input bit cr);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, vr, cr);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_credit"}, 32'(o_credit), 32'd0);
    check_eq({tag, "_vend_valid"}, 32'(o_vend_valid), 32'd0);
    check_eq({tag, "_vend_id"}, 32'(o_vend_id), 32'd0);
    check_eq({tag, "_coin_valid"}, 32'(o_coin_valid), 32'd0);
    check_eq({tag, "_coin_type"}, 32'(o_coin_type), 32'd0);
    check_eq({tag, "_reject"}, 32'(o_coin_reject), 32'd0);
    check_eq({tag, "_denied"}, 32'(o_sel_denied), 32'd0);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge i_clk);
    check_all_zero("reset");
    ni_rst = 1'b1;

    // Quarter, 20c product, nickel change
    coin_in(0, 0, 1); select(2'd1); idle_cyc(1, 0); idle_cyc(0, 1); idle_cyc(0, 0);

    // 60c, 25c product, 35c change with a stalled coin dispenser
    coin_in(0, 0, 1); coin_in(0, 0, 1); coin_in(0, 1, 0); select(2'd0);
    idle_cyc(0, 0); idle_cyc(1, 0);
    idle_cyc(0, 0); idle_cyc(0, 0); idle_cyc(0, 0);
    idle_cyc(0, 1); idle_cyc(0, 0); idle_cyc(0, 1); idle_cyc(0, 0);

    // Two coins in one cycle
    coin_in(1, 1, 0); coin_in(1, 0, 1);

    // Ceiling: build 95c, then a dime is refused, a nickel reaches exactly 100
    coin_in(0, 0, 1); coin_in(0, 0, 1); coin_in(0, 0, 1); coin_in(0, 1, 0); coin_in(0, 1, 0);
    coin_in(0, 1, 0); coin_in(1, 0, 0); coin_in(1, 0, 0);
    step(0, 0, 0, 0, '0, 1, 0, 0);
    repeat (6) idle_cyc(0, 1);

    // Insufficient credit, then cancel returns the nickel
    coin_in(1, 0, 0); select(2'd3); step(0, 0, 0, 0, '0, 1, 0, 0); idle_cyc(0, 1);

    // Cancel with 40c: quarter, dime, nickel
    coin_in(0, 0, 1); coin_in(0, 1, 0); coin_in(1, 0, 0);
    step(0, 0, 0, 0, '0, 1, 0, 0); idle_cyc(0, 1); idle_cyc(0, 1); idle_cyc(0, 1);

    // Cancel and selection together: refund only, coin that cycle rejected
    coin_in(0, 0, 1); step(1, 0, 0, 1, 2'd3, 1, 0, 0); idle_cyc(0, 1); idle_cyc(0, 0);

    // Coin during vend, exact-price vend returns straight to idle
    coin_in(1, 0, 0); coin_in(1, 0, 0); select(2'd3);
    coin_in(0, 0, 1); idle_cyc(1, 0); idle_cyc(0, 0);

    // Selection from idle with no credit, and selection ignored while busy
    select(2'd2); coin_in(0, 0, 1); select(2'd3); select(2'd0); idle_cyc(1, 0);
    step(0, 0, 0, 1, 2'd3, 1, 0, 0); idle_cyc(0, 1); idle_cyc(0, 1);

    // Reset in the middle of change return
    coin_in(0, 0, 1); coin_in(0, 0, 1); select(2'd3); idle_cyc(1, 0); idle_cyc(0, 0);
    ni_rst = 1'b0;
    #1;
    check_all_zero("mid_change_reset");
    model_reset();
    @(negedge i_clk);
    check_outputs();
    ni_rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int  r = $urandom_range(0, 11);
      bit  n = 0, d = 0, q = 0;
      case (r)
        0, 1:    n = 1;
        2, 3:    d = 1;
        4, 5:    q = 1;
        6: begin
          n = 1'($urandom); d = 1'($urandom); q = 1'($urandom);
        end
        default: ;
      endcase
      step(n, d, q, ($urandom_range(0, 7) == 0), SEL_W'($urandom),
           ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
